// File: rtl/comparator_1_bit_pkg.sv
// Shared types and constants for the 1-bit magnitude comparator slice.
// Optional cascade support is selected with COMPARATOR_1_BIT_CASCADE_EN.
package comparator_pkg;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_result_t;

  // All-zero means "no result yet"; every real result is one-hot.
  localparam cmp_result_t CMP_NONE = 3'b000;
  localparam cmp_result_t CMP_LT   = 3'b100;
  localparam cmp_result_t CMP_EQ   = 3'b010;
  localparam cmp_result_t CMP_GT   = 3'b001;

  localparam int PIPE_STAGES_MAX = 4;

endpackage

// File: rtl/comparator_1_bit_if.sv
// Operand, cascade and result bundle for comparator_1_bit.
// Cascade signals exist only when COMPARATOR_1_BIT_CASCADE_EN is defined.
interface comparator_1_bit_if;

  logic Data_A_In;
  logic Data_B_In;
`ifdef COMPARATOR_1_BIT_CASCADE_EN
  logic Less_In;
  logic Equal_In;
  logic Greater_In;
`endif
  logic A_Less_Than_B_Out;
  logic A_Equal_To_B_Out;
  logic A_Greater_Than_B_Out;

`ifdef COMPARATOR_1_BIT_CASCADE_EN
  modport master (
    output Data_A_In, Data_B_In, Less_In, Equal_In, Greater_In,
    input  A_Less_Than_B_Out, A_Equal_To_B_Out, A_Greater_Than_B_Out
  );

  modport slave (
    input  Data_A_In, Data_B_In, Less_In, Equal_In, Greater_In,
    output A_Less_Than_B_Out, A_Equal_To_B_Out, A_Greater_Than_B_Out
  );
`else
  modport master (
    output Data_A_In, Data_B_In,
    input  A_Less_Than_B_Out, A_Equal_To_B_Out, A_Greater_Than_B_Out
  );

  modport slave (
    input  Data_A_In, Data_B_In,
    output A_Less_Than_B_Out, A_Equal_To_B_Out, A_Greater_Than_B_Out
  );
`endif

endinterface

// File: rtl/comparator_1_bit_core.sv
// Combinational single-bit compare with optional cascade resolve
// (COMPARATOR_1_BIT_CASCADE_EN); always produces a one-hot result.
module comparator_1_bit_core
  import comparator_pkg::*;
(
  input  logic        data_a,
  input  logic        data_b,
`ifdef COMPARATOR_1_BIT_CASCADE_EN
  input  logic        less_in,
  input  logic        equal_in,
  input  logic        greater_in,
`endif
  output cmp_result_t result
);

  // A local difference always wins; a tie defers to the lower slices.
  always_comb begin
    result = CMP_EQ;
    if (data_a && !data_b) begin
      result = CMP_GT;
    end else if (!data_a && data_b) begin
      result = CMP_LT;
    end else begin
`ifdef COMPARATOR_1_BIT_CASCADE_EN
      if (greater_in) begin
        result = CMP_GT;
      end else if (less_in) begin
        result = CMP_LT;
      end else if (equal_in) begin
        result = CMP_EQ;
      end else begin
        result = CMP_EQ;
      end
`else
      result = CMP_EQ;
`endif
    end
  end

endmodule

// File: rtl/comparator_1_bit.sv
// Registered 1-bit magnitude comparator with PIPE_STAGES result registers.
// Define COMPARATOR_1_BIT_CASCADE_EN to enable the cascade inputs.
module comparator_1_bit
  import comparator_pkg::*;
#(
  parameter int PIPE_STAGES = 1
) (
  input logic                Clock_In,
  input logic                Reset_N_In,
  comparator_1_bit_if.slave  cmp_bus
);

  generate
    if (PIPE_STAGES < 1 || PIPE_STAGES > PIPE_STAGES_MAX) begin : g_bad_stages
      $error("comparator_1_bit: PIPE_STAGES must be in 1..4");
    end
  endgenerate

  cmp_result_t core_result;
  cmp_result_t stage_q [PIPE_STAGES];
  cmp_result_t out_result;
  logic [2:0]  fill_cnt;

  comparator_1_bit_core u_core (
    .data_a     (cmp_bus.Data_A_In),
    .data_b     (cmp_bus.Data_B_In),
`ifdef COMPARATOR_1_BIT_CASCADE_EN
    .less_in    (cmp_bus.Less_In),
    .equal_in   (cmp_bus.Equal_In),
    .greater_in (cmp_bus.Greater_In),
`endif
    .result     (core_result)
  );

  // Reset clears every stage at once, so in-flight results are dropped.
  genvar i;
  generate
    for (i = 0; i < PIPE_STAGES; i++) begin : g_stage
      if (i == 0) begin : g_first
        always_ff @(posedge Clock_In or negedge Reset_N_In) begin
          if (!Reset_N_In) stage_q[i] <= CMP_NONE;
          else             stage_q[i] <= core_result;
        end
      end else begin : g_next
        always_ff @(posedge Clock_In or negedge Reset_N_In) begin
          if (!Reset_N_In) stage_q[i] <= CMP_NONE;
          else             stage_q[i] <= stage_q[i-1];
        end
      end
    end
  endgenerate

  assign out_result                   = stage_q[PIPE_STAGES-1];
  assign cmp_bus.A_Less_Than_B_Out    = out_result.lt;
  assign cmp_bus.A_Equal_To_B_Out     = out_result.eq;
  assign cmp_bus.A_Greater_Than_B_Out = out_result.gt;

  // Counts edges since reset so the checker knows when outputs must be one-hot.
  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In)                        fill_cnt <= 3'd0;
    else if (fill_cnt != 3'(PIPE_STAGES))   fill_cnt <= fill_cnt + 3'd1;
  end

  a_never_multi_hot: assert property (
    @(posedge Clock_In) disable iff (!Reset_N_In) $onehot0(out_result)
  ) else $error("comparator_1_bit: multi-hot result %b", out_result);

  a_one_hot_when_full: assert property (
    @(posedge Clock_In) disable iff (!Reset_N_In)
      (fill_cnt == 3'(PIPE_STAGES)) |-> $onehot(out_result)
  ) else $error("comparator_1_bit: result not one-hot %b", out_result);

endmodule

// File: tb/tb_comparator_1_bit.sv
// Scoreboarded bench driving a 1-stage and a 3-stage comparator in parallel.
// Cascade checks are added when COMPARATOR_1_BIT_CASCADE_EN is defined.
module tb_comparator_1_bit;
  import comparator_pkg::*;

  logic clk;
  logic rst_n;
  logic a_sig, b_sig, lt_sig, eq_sig, gt_sig;

  int testCount = 0;
  int failCount = 0;

  cmp_result_t q1[$];
  cmp_result_t q3[$];

  comparator_1_bit_if bus1 ();
  comparator_1_bit_if bus3 ();

  assign bus1.Data_A_In = a_sig;
  assign bus1.Data_B_In = b_sig;
  assign bus3.Data_A_In = a_sig;
  assign bus3.Data_B_In = b_sig;
`ifdef COMPARATOR_1_BIT_CASCADE_EN
  assign bus1.Less_In    = lt_sig;
  assign bus1.Equal_In   = eq_sig;
  assign bus1.Greater_In = gt_sig;
  assign bus3.Less_In    = lt_sig;
  assign bus3.Equal_In   = eq_sig;
  assign bus3.Greater_In = gt_sig;
`endif

  comparator_1_bit #(.PIPE_STAGES(1)) dut1 (
    .Clock_In   (clk),
    .Reset_N_In (rst_n),
    .cmp_bus    (bus1)
  );

  comparator_1_bit #(.PIPE_STAGES(3)) dut3 (
    .Clock_In   (clk),
    .Reset_N_In (rst_n),
    .cmp_bus    (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour written from the truth table, not from the RTL.
  function automatic cmp_result_t refModel();
    cmp_result_t r;
    if (a_sig == 1'b1 && b_sig == 1'b0)      r = CMP_GT;
    else if (a_sig == 1'b0 && b_sig == 1'b1) r = CMP_LT;
`ifdef COMPARATOR_1_BIT_CASCADE_EN
    else if (gt_sig)                         r = CMP_GT;
    else if (lt_sig)                         r = CMP_LT;
    else                                     r = CMP_EQ;
`else
    else                                     r = CMP_EQ;
`endif
    return r;
  endfunction

  function automatic cmp_result_t observed1();
    return {bus1.A_Less_Than_B_Out, bus1.A_Equal_To_B_Out, bus1.A_Greater_Than_B_Out};
  endfunction

  function automatic cmp_result_t observed3();
    return {bus3.A_Less_Than_B_Out, bus3.A_Equal_To_B_Out, bus3.A_Greater_Than_B_Out};
  endfunction

  task automatic resetScoreboard();
    q1.delete();
    q3.delete();
    repeat (2) q3.push_back(CMP_NONE);
  endtask

  task automatic applyStimulus(input logic a, input logic b,
                               input logic lt, input logic eq, input logic gt);
    @(negedge clk);
    a_sig  = a;
    b_sig  = b;
    lt_sig = lt;
    eq_sig = eq;
    gt_sig = gt;
  endtask

  task automatic compareBoth(input string tag, input cmp_result_t exp1,
                             input cmp_result_t exp3);
    cmp_result_t obs1, obs3;
    obs1 = observed1();
    obs3 = observed3();
    testCount++;
    assert (obs1 === exp1) else begin
      failCount++;
      $error("[TB] FAIL %s/p1: observed=%b expected=%b", tag, obs1, exp1);
    end
    testCount++;
    assert (obs3 === exp3) else begin
      failCount++;
      $error("[TB] FAIL %s/p3: observed=%b expected=%b", tag, obs3, exp3);
    end
  endtask

  // One rising edge: inputs captured here are queued, the matured result is popped.
  task automatic checkOutput(input string tag);
    cmp_result_t exp1, exp3;
    @(posedge clk);
    if (rst_n) begin
      q1.push_back(refModel());
      q3.push_back(refModel());
      exp1 = (q1.size() > 0) ? q1.pop_front() : CMP_NONE;
      exp3 = (q3.size() > 0) ? q3.pop_front() : CMP_NONE;
    end else begin
      exp1 = CMP_NONE;
      exp3 = CMP_NONE;
    end
    #1;
    compareBoth(tag, exp1, exp3);
  endtask

  initial begin
    rst_n  = 1'b0;
    a_sig  = 1'b1;
    b_sig  = 1'b0;
    lt_sig = 1'b0;
    eq_sig = 1'b0;
    gt_sig = 1'b0;
    resetScoreboard();

    // Held in reset with A>B presented: outputs stay all-zero.
    repeat (3) checkOutput("in_reset");

    @(negedge clk);
    rst_n = 1'b1;
    resetScoreboard();
    repeat (4) checkOutput("release_fill");

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); checkOutput("sweep_00");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); checkOutput("sweep_01");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); checkOutput("sweep_10");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); checkOutput("sweep_11");

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); checkOutput("pulse_lt");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) checkOutput("pulse_tail");

    // Reset pulled between edges while the 1-stage slice shows Greater.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_async");
    #2;
    rst_n = 1'b0;
    #1;
    compareBoth("async_reset", CMP_NONE, CMP_NONE);
    resetScoreboard();
    checkOutput("async_hold");
    @(negedge clk);
    rst_n = 1'b1;
    resetScoreboard();
    repeat (3) checkOutput("refill");

`ifdef COMPARATOR_1_BIT_CASCADE_EN
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); checkOutput("casc_lt");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1); checkOutput("casc_gt_over_lt");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); checkOutput("casc_none");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0); checkOutput("casc_eq");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); checkOutput("casc_local_wins");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1); checkOutput("casc_local_lt");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) checkOutput("casc_drain");
`endif

    for (int n = 0; n < 10; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      checkOutput("random");
    end
    repeat (3) checkOutput("random_drain");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
